rst_seq_gen: RTL and testbench



---
 rtl/rst_seq_gen.sv | 151 +++++++++++++++
 tb/tb_rst_seq_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Reset sequencer: holds all downstream resets, then releases them one by one,
// waiting for each domain's synchronized acknowledge (or a timeout) in between.
module rst_seq_gen #(
  parameter int HOLD_CYCLES = 16,
  parameter int NUM_OUT     = 2,
  parameter int GAP_CYCLES  = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  output logic [NUM_OUT-1:0] rst_n_out,
  input  logic [NUM_OUT-1:0] ack_in,
  output logic               busy,
  output logic               done,
  output logic               timeout
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_HG > ACK_TIMEOUT) ? MAX_HG : ACK_TIMEOUT;
  localparam int CW     = $clog2(MAX_C + 1);
  localparam int IW     = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_GAP      = 2'd2,
    S_IDLE     = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_n_q, rst_n_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;

  function automatic logic [NUM_OUT-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_OUT-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      v[k] = (IW'(k) == i);
    end
    return v;
  endfunction

  // State and registered outputs; reset restarts the sequence from HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_n_q   <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_n_q   <= rst_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state; a restart request overrides any same-edge completion or timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_n_d   = rst_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    timeout_d = timeout_q;
    if (req) begin
      state_d   = S_HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_n_d   = '0;
      busy_d    = 1'b1;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_n_d = onehot('0);
            cnt_d   = '0;
            idx_d   = '0;
            state_d = S_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_ACK: begin
          // A timed-out ack is flagged and then treated exactly like a real one.
          if (ack_in[idx_q] || (cnt_q == ACK_LAST)) begin
            timeout_d = timeout_q | ~ack_in[idx_q];
            cnt_d     = '0;
            if (idx_q == IDX_LAST) begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else if (GAP_CYCLES == 0) begin
              idx_d   = idx_q + 1'b1;
              rst_n_d = rst_n_q | onehot(idx_q + 1'b1);
            end else begin
              state_d = S_GAP;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            idx_d   = idx_q + 1'b1;
            rst_n_d = rst_n_q | onehot(idx_q + 1'b1);
            cnt_d   = '0;
            state_d = S_WAIT_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  assign rst_n_out = rst_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed bench for rst_seq_gen: default config (A) and GAP_CYCLES=0/NUM_OUT=3 (B),
// each downstream domain modelled as a two-flop synchronizer feeding back its ack.
module tb_rst_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, req_a, req_b;
  logic [1:0] rst_a, ack_a, sync_a, mask_a;
  logic       busy_a, done_a, to_a;
  logic [2:0] rst_b, ack_b, sync_b;
  logic       busy_b, done_b, to_b;

  int edge_cnt   = 0;
  int total      = 0;
  int bad        = 0;
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int snap;

  rst_seq_gen u_a (
    .clk(clk), .reset(reset), .req(req_a), .rst_n_out(rst_a),
    .ack_in(ack_a), .busy(busy_a), .done(done_a), .timeout(to_a)
  );

  rst_seq_gen #(.NUM_OUT(3), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .req(req_b), .rst_n_out(rst_b),
    .ack_in(ack_b), .busy(busy_b), .done(done_b), .timeout(to_b)
  );

  // Edge numbering restarts with reset; acks are rst_n_out delayed two cycles.
  always @(posedge clk) begin
    edge_cnt <= reset ? 0 : edge_cnt + 1;
    sync_a   <= rst_a & mask_a;
    ack_a    <= sync_a;
    sync_b   <= rst_b;
    ack_b    <= sync_b;
  end

  always @(negedge clk) begin
    if (done_a === 1'b1) done_cnt_a <= done_cnt_a + 1;
    if (done_b === 1'b1) done_cnt_b <= done_cnt_b + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_cnt);
    end
  endtask

  task automatic to_edge(input int n);
    int i;
    i = 0;
    while (edge_cnt != n && i < 2000) begin
      @(posedge clk);
      #1;
      i++;
    end
    if (edge_cnt != n) check("edge_wait", edge_cnt, n);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst_a"},  rst_a,  2'b00);
    check({tag, "_busy_a"}, busy_a, 1'b1);
    check({tag, "_done_a"}, done_a, 1'b0);
    check({tag, "_to_a"},   to_a,   1'b0);
    check({tag, "_rst_b"},  rst_b,  3'b000);
    check({tag, "_busy_b"}, busy_b, 1'b1);
  endtask

  task automatic run_default_timing(input string tag);
    to_edge(15);
    check({tag, "_hold_a"}, rst_a, 2'b00);
    check({tag, "_hold_b"}, rst_b, 3'b000);
    to_edge(16);
    check({tag, "_rel0_a"}, rst_a, 2'b01);
    check({tag, "_rel0_b"}, rst_b, 3'b001);
    to_edge(19);
    check({tag, "_rel1_b"}, rst_b, 3'b011);
    check({tag, "_gap_a"},  rst_a, 2'b01);
    to_edge(22);
    check({tag, "_rel2_b"}, rst_b, 3'b111);
    check({tag, "_pre_a"},  rst_a, 2'b01);
    to_edge(23);
    check({tag, "_rel1_a"}, rst_a, 2'b11);
    check({tag, "_busy23"}, busy_a, 1'b1);
    to_edge(25);
    check({tag, "_done_b"}, done_b, 1'b1);
    check({tag, "_idle_b"}, busy_b, 1'b0);
    check({tag, "_nodone"}, done_a, 1'b0);
    to_edge(26);
    check({tag, "_done_a"}, done_a, 1'b1);
    check({tag, "_idle_a"}, busy_a, 1'b0);
    check({tag, "_to_a"},   to_a,   1'b0);
    check({tag, "_done1b"}, done_b, 1'b0);
    to_edge(27);
    check({tag, "_done1a"}, done_a, 1'b0);
    check({tag, "_allrel"}, rst_a, 2'b11);
  endtask

  initial begin
    reset  = 1'b1;
    req_a  = 1'b0;
    req_b  = 1'b0;
    mask_a = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    reset = 1'b0;
    run_default_timing("pwr");
    check("pwr_dcnt_a", done_cnt_a, 1);
    check("pwr_dcnt_b", done_cnt_b, 1);

    // ack[1] never arrives
    mask_a = 2'b01;
    reset_pulse();
    to_edge(86);
    check("to_pre", to_a, 1'b0);
    check("to_pre_done", done_a, 1'b0);
    check("to_pre_rst", rst_a, 2'b11);
    to_edge(87);
    check("to_set", to_a, 1'b1);
    check("to_done", done_a, 1'b1);
    check("to_busy", busy_a, 1'b0);
    to_edge(88);
    check("to_sticky", to_a, 1'b1);
    check("to_done_end", done_a, 1'b0);

    // restart by request clears the sticky timeout
    mask_a = 2'b11;
    to_edge(89);
    req_a = 1'b1;
    to_edge(90);
    req_a = 1'b0;
    check("req_to_clr", to_a, 1'b0);
    check("req_rst", rst_a, 2'b00);
    check("req_busy", busy_a, 1'b1);
    snap = done_cnt_a;

    // request on the edge that samples the final ack
    to_edge(115);
    check("fin_pre_rst", rst_a, 2'b11);
    req_a = 1'b1;
    to_edge(116);
    req_a = 1'b0;
    check("fin_done", done_a, 1'b0);
    check("fin_busy", busy_a, 1'b1);
    check("fin_rst", rst_a, 2'b00);

    // request on the edge that would time out
    mask_a = 2'b01;
    to_edge(202);
    check("rto_pre_rst", rst_a, 2'b11);
    check("rto_pre_to", to_a, 1'b0);
    req_a = 1'b1;
    to_edge(203);
    req_a = 1'b0;
    check("rto_to", to_a, 1'b0);
    check("rto_done", done_a, 1'b0);
    check("rto_rst", rst_a, 2'b00);

    // request while in GAP
    mask_a = 2'b11;
    to_edge(222);
    check("gap_pre", rst_a, 2'b01);
    to_edge(223);
    req_a = 1'b1;
    to_edge(224);
    req_a = 1'b0;
    check("gap_rst", rst_a, 2'b00);
    check("gap_busy", busy_a, 1'b1);
    to_edge(239);
    check("gap_hold", rst_a, 2'b00);
    to_edge(240);
    check("gap_rel0", rst_a, 2'b01);
    check("no_done", done_cnt_a, snap);

    // one-cycle reset while waiting for ack[0]
    reset_pulse();
    check_reset_vals("mid");
    run_default_timing("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
